neuron_mac_l1: RTL and testbench
================================

Name: neuron_mac_l1

Overview:
- Layer-1 neuron compute stage. Sits directly downstream of the layer-1 index counter.
- The counter's index selects the weight/input pair to fetch. On each index change, the block reads one weight and one input from synchronous memories, multiplies them in fixed point and accumulates.
- After NUM_INPUTS products it adds the bias, applies ReLU with saturation, and presents one activation with a valid pulse to the layer-2 stage.

Parameters:
- DATA_W, 16: signed width of weight, input, bias and output. Fixed point with FRAC_BITS fractional bits.
- FRAC_BITS, 8: fractional bits of all DATA_W quantities.
- ACC_W, 40: signed accumulator width.
- NUM_INPUTS, 784: number of products per neuron evaluation.
- ADDR_W, 10: memory address width. Must satisfy 2^ADDR_W >= NUM_INPUTS.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins an evaluation.
- index  in  32  index from the upstream counter.
- bias  in  DATA_W  signed bias. Sampled on the cycle start is accepted.
- mem_addr  out  ADDR_W  read address shared by the weight and input memories.
- mem_rd  out  1  read strobe.
- w_data  in  DATA_W  signed weight. Valid 1 cycle after mem_rd.
- x_data  in  DATA_W  signed input. Valid 1 cycle after mem_rd.
- busy  out  1  high whenever the block is not in IDLE.
- out_data  out  DATA_W  activation result. Held until the next result.
- out_valid  out  1  one-cycle pulse when out_data updates.

Behaviour:
- Reset (async, rstn=0) values:
  - Outputs: busy=0, out_valid=0, out_data=0, mem_rd=0, mem_addr=0.
  - Internal: acc=0, count=0, idx_q=0, state=IDLE.
  - Reset asserted mid-evaluation aborts it. No out_valid is produced.
- States: IDLE, ACCUM, BIAS, ACT.
- IDLE:
  - start=1 moves to ACCUM and clears acc and count.
  - bias is latched and idx_q is loaded with the current index, so the index already present does not trigger a read.
  - Index changes in IDLE are ignored.
- ACCUM, stage 0:
  - When index != idx_q and issued < NUM_INPUTS: mem_rd=1 and mem_addr=index[ADDR_W-1:0] for exactly one cycle, then idx_q<=index.
  - Back-to-back changes on consecutive cycles must each issue a read.
- ACCUM, stage 1:
  - The cycle after mem_rd, the block computes prod = w_data*x_data (2*DATA_W signed) and shifts it arithmetically right by FRAC_BITS.
  - The result is sign-extended to ACC_W and added to acc. count increments.
  - The addition saturates to the ACC_W signed range; it does not wrap.
- ACCUM exit:
  - When count reaches NUM_INPUTS, with the last product accumulated in the same cycle, the next state is BIAS.
  - Index changes after NUM_INPUTS reads have been issued are ignored.
- BIAS: acc <= sat(acc + sign-extended bias). One cycle, then ACT.
- ACT:
  - out_data <= 0 if acc < 0.
  - Otherwise out_data <= min(acc, 2^(DATA_W-1)-1).
  - out_valid=1 for this single cycle, then IDLE. busy drops on the same edge.
- Latency: last read issued, then 4 clocks to out_valid (product, BIAS, ACT, register).
- start asserted while busy=1 is ignored. Does not restart or extend the evaluation.
- start and an index change in the same IDLE cycle: start is accepted; the new index is absorbed into idx_q with no read.
- The index MSB and any bits above ADDR_W are ignored for addressing. Wrap-around of index (e.g. 0xFFFFFFFF to 0) counts as a change.

Test Plan:
- NUM_INPUTS=4, bias=0x0100 (1.0); weights 0x0100, 0x0200, 0x0080, 0x0100; inputs all 0x0100; four index changes -> out_data=0x0580 (5.5), one out_valid pulse 4 cycles after the 4th read.
- Same setup with bias=0xF000 (-16.0) -> acc negative, out_data=0x0000, out_valid pulses once.
- All weights and inputs 0x7FFF, NUM_INPUTS=4 -> out_data saturates to 0x7FFF, with no wrap to negative.
- Index held constant for 20 cycles after start -> no mem_rd, busy stays 1, out_valid stays 0. A start pulse during this wait is ignored.
- Index changing every cycle (counter bypassed) -> exactly 4 mem_rd pulses with addresses matching the index low bits. Result matches the first scenario.
- rstn pulsed low after 2 products -> all outputs 0 immediately (asynchronous). A new start then yields the correct full result with no carry-over of acc.

Source files
------------

// File: rtl/neuron_mac_l1.sv
// neuron_mac_l1
// Layer-1 neuron compute stage. Each change of the upstream index during an
// evaluation fetches one weight/input pair from synchronous memories. The pair
// is multiplied in fixed point and accumulated with saturation. After
// NUM_INPUTS products the stage adds the bias, applies ReLU with an upper
// clamp, and presents one activation with a single-cycle valid pulse.
//
// Ports:
//   clk       rising-edge clock
//   rstn      asynchronous active-low reset
//   start     one-cycle pulse that begins an evaluation (ignored while busy)
//   index     upstream counter index; a change requests one memory read
//   bias      signed bias, sampled when start is accepted
//   mem_addr  read address shared by the weight and input memories
//   mem_rd    read strobe
//   w_data    signed weight, valid one cycle after mem_rd
//   x_data    signed input, valid one cycle after mem_rd
//   busy      high whenever the block is not idle
//   out_data  activation result, held until the next result
//   out_valid one-cycle pulse when out_data updates

module neuron_mac_l1 #(
  parameter int DATA_W     = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ACC_W      = 40,
  parameter int NUM_INPUTS = 784,
  parameter int ADDR_W     = 10
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [31:0]              index,
  input  logic signed [DATA_W-1:0] bias,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_rd,
  input  logic signed [DATA_W-1:0] w_data,
  input  logic signed [DATA_W-1:0] x_data,
  output logic                     busy,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] BIAS  = 2'd2;
  localparam logic [1:0] ACT   = 2'd3;

  // Counters must be able to hold NUM_INPUTS itself.
  localparam int CNT_W = $clog2(NUM_INPUTS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_INPUTS);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] OUT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};

  logic [1:0]               state;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         count;
  logic [CNT_W-1:0]         issued;
  logic [31:0]              idx_q;
  logic signed [DATA_W-1:0] bias_q;
  logic                     rd_q;

  logic                       rd_req;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [2*DATA_W-1:0] prod_sh;
  logic signed [ACC_W-1:0]    term;
  logic signed [ACC_W-1:0]    bias_ext;
  logic signed [ACC_W-1:0]    acc_prod;
  logic signed [ACC_W-1:0]    acc_bias;
  logic [CNT_W-1:0]           count_inc;
  logic [DATA_W-1:0]          act_val;

  // Add two accumulator-width values, clamping to the signed range instead of
  // wrapping. Overflow shows up as disagreement between the two top bits of
  // the one-bit-wider sum.
  function automatic logic signed [ACC_W-1:0] sat_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    logic signed [ACC_W:0]   s;
    logic signed [ACC_W-1:0] r;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1]) begin
      r = s[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      r = s[ACC_W-1:0];
    end
    return r;
  endfunction

  // A read is issued combinationally in the cycle the index differs from the
  // last one seen, so back-to-back index changes each get their own read.
  // The full 32-bit index is compared, so a wrap-around counts as a change.
  assign rd_req   = (state == ACCUM) && (index != idx_q) && (issued < LAST);
  assign mem_rd   = rd_req;
  assign mem_addr = rd_req ? index[ADDR_W-1:0] : '0;
  assign busy     = (state != IDLE);

  assign prod      = w_data * x_data;
  assign prod_sh   = prod >>> FRAC_BITS;
  assign term      = {{(ACC_W-2*DATA_W){prod_sh[2*DATA_W-1]}}, prod_sh};
  assign bias_ext  = {{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q};
  assign acc_prod  = sat_add(acc, term);
  assign acc_bias  = sat_add(acc, bias_ext);
  assign count_inc = count + 1'b1;

  // ReLU with a clamp to the largest positive output value.
  always_comb begin
    act_val = '0;
    if (acc[ACC_W-1]) begin
      act_val = '0;
    end else if (acc > OUT_MAX) begin
      act_val = OUT_MAX[DATA_W-1:0];
    end else begin
      act_val = acc[DATA_W-1:0];
    end
  end

  // Main sequencer. rd_q marks the cycle where memory data for the previous
  // read is on w_data/x_data; that product is accumulated on the next edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      issued    <= '0;
      idx_q     <= '0;
      bias_q    <= '0;
      rd_q      <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= ACCUM;
            acc    <= '0;
            count  <= '0;
            issued <= '0;
            bias_q <= bias;
            idx_q  <= index;
            rd_q   <= 1'b0;
          end
        end
        ACCUM: begin
          rd_q <= rd_req;
          if (rd_req) begin
            idx_q  <= index;
            issued <= issued + 1'b1;
          end
          if (rd_q) begin
            acc   <= acc_prod;
            count <= count_inc;
            if (count_inc == LAST) begin
              state <= BIAS;
            end
          end
        end
        BIAS: begin
          acc   <= acc_bias;
          state <= ACT;
        end
        ACT: begin
          out_data  <= act_val;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_l1.sv
// tb_neuron_mac_l1
// Scoreboard bench for neuron_mac_l1 with NUM_INPUTS=4. Stimulus pushes the
// expected read addresses and the expected activation into queues; a monitor
// on the falling edge pops and compares whenever the DUT reads or presents a
// result. Expected activations come from a plain arithmetic reference model.

module tb_neuron_mac_l1;

  localparam int DW  = 16;
  localparam int AW  = 10;
  localparam int NUM = 4;

  logic              clk;
  logic              rstn;
  logic              start;
  logic [31:0]       index;
  logic signed [DW-1:0] bias;
  logic [AW-1:0]     mem_addr;
  logic              mem_rd;
  logic signed [DW-1:0] w_data;
  logic signed [DW-1:0] x_data;
  logic              busy;
  logic [DW-1:0]     out_data;
  logic              out_valid;

  logic signed [DW-1:0] wmem [1024];
  logic signed [DW-1:0] xmem [1024];
  logic [31:0]          seq [NUM];

  longint    expq[$];
  logic [AW-1:0] addrq[$];
  int        total = 0;
  int        bad = 0;
  int        cycle = 0;
  int        last_rd = 0;
  longint    last_exp = 0;

  neuron_mac_l1 #(
    .DATA_W(DW), .FRAC_BITS(8), .ACC_W(40), .NUM_INPUTS(NUM), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .index(index), .bias(bias),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .w_data(w_data), .x_data(x_data),
    .busy(busy), .out_data(out_data), .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used for the read-to-result latency check.
  always @(posedge clk) cycle <= cycle + 1;

  // Synchronous weight/input memories: data appears one cycle after mem_rd.
  always @(posedge clk) begin
    if (mem_rd) begin
      w_data <= wmem[mem_addr];
      x_data <= xmem[mem_addr];
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic longint sat40(input longint v);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< 39) - 1;
    lo = -(longint'(1) <<< 39);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Reference model: sum of fixed-point products, plus bias, ReLU, clamp.
  function automatic longint model(input logic signed [DW-1:0] b);
    longint acc;
    longint p;
    acc = 0;
    for (int i = 0; i < NUM; i++) begin
      p = longint'(wmem[seq[i][AW-1:0]]) * longint'(xmem[seq[i][AW-1:0]]);
      acc = sat40(acc + (p >>> 8));
    end
    acc = sat40(acc + longint'(b));
    if (acc < 0) return 0;
    if (acc > 32767) return 32767;
    return acc;
  endfunction

  // Monitor: every read and every result is matched against the queues.
  always @(negedge clk) begin
    if (rstn) begin
      if (mem_rd) begin
        if (addrq.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL unexpected_rd: got addr %0h expected no read", mem_addr);
        end else begin
          checkOutput("rd_addr", longint'(mem_addr), longint'(addrq.pop_front()));
        end
        last_rd = cycle;
      end
      if (out_valid) begin
        if (expq.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL unexpected_valid: got data %0h expected no result", out_data);
        end else begin
          checkOutput("out_data", longint'(out_data), expq.pop_front());
        end
        checkOutput("latency", longint'(cycle - last_rd), 4);
      end
    end
  end

  task automatic waitIdle();
    bit done;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk); #1;
      if (!busy) done = 1;
    end
    if (!done) begin
      total++; bad++;
      $display("[TB] FAIL timeout: got busy=1 expected idle within 60 cycles");
    end
  endtask

  task automatic fillDirected(input logic signed [DW-1:0] w0, input logic signed [DW-1:0] w1,
                              input logic signed [DW-1:0] w2, input logic signed [DW-1:0] w3,
                              input logic signed [DW-1:0] xv);
    seq[0] = 32'h10; seq[1] = 32'h11; seq[2] = 32'h12; seq[3] = 32'h13;
    wmem[16] = w0; wmem[17] = w1; wmem[18] = w2; wmem[19] = w3;
    for (int i = 16; i < 20; i++) xmem[i] = xv;
  endtask

  task automatic fillRandom();
    int v;
    for (int i = 0; i < 1024; i++) begin
      v = int'($urandom_range(0, 2048)); wmem[i] = 16'(v - 1024);
      v = int'($urandom_range(0, 2048)); xmem[i] = 16'(v - 1024);
    end
  endtask

  // One full evaluation: start pulse, optional hold with ignored start,
  // NUM index changes with random gaps, then extra index changes that must
  // not produce reads.
  task automatic applyStimulus(input logic signed [DW-1:0] b, input logic [31:0] start_idx,
                               input int gap_max, input int hold, input bit poke);
    int gap;
    last_exp = model(b);
    @(posedge clk); #1;
    start = 1'b1; bias = b; index = start_idx;
    expq.push_back(last_exp);
    @(posedge clk); #1;
    start = 1'b0; bias = 16'($urandom);
    checkOutput("busy_after_start", longint'(busy), 1);
    for (int h = 0; h < hold; h++) begin
      if (poke && h == hold / 2) begin
        start = 1'b1; bias = ~b;
      end
      checkOutput("busy_hold", longint'(busy), 1);
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int i = 0; i < NUM; i++) begin
      if (poke && i == 2) begin
        start = 1'b1; bias = ~b;
        @(posedge clk); #1;
        start = 1'b0;
      end
      index = seq[i];
      addrq.push_back(seq[i][AW-1:0]);
      @(posedge clk); #1;
      gap = int'($urandom_range(0, gap_max));
      repeat (gap) begin @(posedge clk); #1; end
    end
    index = index + 32'd1;
    waitIdle();
    index = index + 32'd1;
    @(posedge clk); #1;
    checkOutput("out_held", longint'(out_data), last_exp);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; index = 32'd0; bias = '0;
    for (int i = 0; i < 1024; i++) begin wmem[i] = '0; xmem[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", longint'(busy), 0);
    checkOutput("rst_valid", longint'(out_valid), 0);
    checkOutput("rst_data", longint'(out_data), 0);
    checkOutput("rst_rd", longint'(mem_rd), 0);
    checkOutput("rst_addr", longint'(mem_addr), 0);
    rstn = 1'b1;

    // Directed: 1.0*1 + 2.0*1 + 0.5*1 + 1.0*1 + bias 1.0 = 5.5.
    fillDirected(16'h0100, 16'h0200, 16'h0080, 16'h0100, 16'h0100);
    applyStimulus(16'h0100, 32'h0F, 2, 0, 1'b0);
    applyStimulus(16'hF000, 32'h20, 1, 0, 1'b0);
    fillDirected(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    applyStimulus(16'h0100, 32'h21, 1, 0, 1'b0);
    fillDirected(16'h0100, 16'h0200, 16'h0080, 16'h0100, 16'h0100);
    applyStimulus(16'h0100, 32'h30, 2, 20, 1'b1);
    applyStimulus(16'h0100, 32'h40, 0, 0, 1'b0);

    // Abort after two products with an asynchronous reset mid-cycle.
    @(posedge clk); #1;
    start = 1'b1; bias = 16'h0100; index = 32'h50;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      index = seq[i];
      addrq.push_back(seq[i][AW-1:0]);
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #2;
    checkOutput("busy_pre_reset", longint'(busy), 1);
    rstn = 1'b0;
    #1;
    checkOutput("areset_busy", longint'(busy), 0);
    checkOutput("areset_valid", longint'(out_valid), 0);
    checkOutput("areset_data", longint'(out_data), 0);
    checkOutput("areset_rd", longint'(mem_rd), 0);
    checkOutput("areset_addr", longint'(mem_addr), 0);
    checkOutput("areset_addrq", longint'(addrq.size()), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    applyStimulus(16'h0100, 32'h60, 1, 0, 1'b0);

    // Index wrap-around counts as a change; upper bits ignored for address.
    fillRandom();
    seq[0] = 32'hFFFFFFFE; seq[1] = 32'hFFFFFFFF; seq[2] = 32'h0; seq[3] = 32'h1;
    applyStimulus(16'(int'($urandom_range(0, 4096)) - 2048), 32'h12345, 2, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      fillRandom();
      seq[0] = $urandom;
      for (int i = 1; i < NUM; i++) begin
        seq[i] = $urandom;
        if (seq[i] == seq[i-1]) seq[i] = seq[i] + 32'd1;
      end
      applyStimulus(16'(int'($urandom_range(0, 4096)) - 2048), ~seq[0], 3, 0, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("expq_drained", longint'(expq.size()), 0);
    checkOutput("addrq_drained", longint'(addrq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
